regincr_rr_sched: RTL and testbench
===================================

Name: regincr_rr_sched

Overview:
Controller that time-shares one registered +1 incrementer datapath among NREQ requesters.
- Each requester submits an 8-bit value and a repeat count over a val/rdy interface.
- The block arbitrates round-robin, then sequences the value through the incrementer once per cycle, count times.
- The result is returned on a single shared val/rdy response port, tagged with the requester id.
- It sits between several client blocks and the single shared incrementer datapath.

Parameters:
NREQ, 4, number of requesters; power of 2, >= 2
W, 8, data width
CW, 4, repeat-count width
IDW, $clog2(NREQ), requester-id width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req_val  input  NREQ  bit i: requester i presents a request
req_rdy  output  NREQ  bit i: requester i is accepted this cycle (one-hot or zero)
req_data  input  NREQ*W  requester i value at bits [i*W +: W]
req_cnt  input  NREQ*CW  requester i repeat count at bits [i*CW +: CW]
resp_val  output  1  response valid
resp_rdy  input  1  consumer can take response
resp_data  output  W  incremented result
resp_id  output  IDW  index of the requester that owns the response
busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (clk is the clock; reset is synchronous, active-high):
  - Sets state=IDLE, priority pointer ptr=0, acc=0, remaining=0, id=0.
  - While reset is high: resp_val=0, req_rdy=0, busy=0, resp_data=0, resp_id=0.
- Reset mid-operation aborts any in-flight job. The job is dropped with no response and ptr returns to 0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - The grant is the first i with req_val[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - req_rdy[grant]=1; all other bits are 0. req_rdy is combinational from req_val, ptr and state; it is 0 outside IDLE.
  - On handshake (req_val[g] & req_rdy[g]): acc<=req_data[g], remaining<=req_cnt[g], id<=g, ptr<=(g+1) mod NREQ.
  - Next state is DONE if req_cnt[g]==0, else BUSY.
  - With no req_val bit set: stay in IDLE, ptr unchanged.
- BUSY:
  - Each cycle: acc<=acc+1 modulo 2^W (0xFF+1=0x00 for W=8; carry discarded), remaining<=remaining-1.
  - When remaining==1 at the edge, next state is DONE.
  - BUSY therefore lasts exactly cnt cycles. New requests are ignored and req_val is not sampled.
- DONE:
  - resp_val=1, resp_data=acc, resp_id=id. All three are registered outputs, stable while resp_val & !resp_rdy.
  - On resp_rdy=1, go to IDLE next cycle. No request is accepted in the same cycle as the response handshake.
- Latency from request handshake edge to resp_val high is cnt+1 cycles. cnt=0 gives 1 cycle with resp_data equal to the input value.
- Throughput is one job at a time. The minimum period between consecutive acceptances is cnt+2 cycles when resp_rdy is held at 1.
- Fairness: a requester holding req_val waits at most NREQ-1 jobs.
- Simultaneous requests are resolved strictly by ptr order. A requester that drops req_val before acceptance is simply not granted; no request state is kept.
- resp_data, acc and the incrementer are W bits. The count is unsigned CW bits; the maximum count is 2^CW-1 = 15.

Test Plan:
- Single request, no repeat: reset, then req_val=4'b0001, data0=0x10, cnt0=1 -> accepted on first cycle; resp_val 2 cycles later with resp_data=0x11, resp_id=0.
- Wrap-around: data2=0xFE, cnt2=3 -> resp_data=0x01, resp_id=2, resp_val 4 cycles after accept.
- Zero count: data1=0x5A, cnt1=0 -> resp_data=0x5A, resp_id=1, resp_val 1 cycle after accept.
- Round-robin: all four req_val held high, cnt=1, data_i=i*0x10, resp_rdy=1 -> grants in order 0,1,2,3,0; responses 0x01,0x11,0x21,0x31; req_rdy never multi-hot.
- Backpressure: resp_rdy=0 for 5 cycles in DONE -> resp_val/resp_data/resp_id held constant, req_rdy=0, busy=1; then resp_rdy=1 -> IDLE next cycle.
- Reset mid-op: data0=0x00, cnt0=10, assert reset during BUSY cycle 4 -> next cycle resp_val=0, busy=0; no response ever appears; a following request to requester 3 with the others also requesting is granted to requester 0 first (ptr=0).

Source files
------------

// File: rtl/regincr_rr_sched.sv
// regincr_rr_sched: shares one registered +1 incrementer among NREQ requesters.
// A round-robin arbiter picks one request, the value is incremented once per
// cycle for its repeat count, and the result is returned tagged with the
// requester id on a single val/rdy response port.
module regincr_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int CW   = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ*CW-1:0] req_cnt,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [W-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [W-1:0]   acc;
  logic [CW-1:0]  remaining;

  logic [IDW-1:0] grant;
  logic [IDW-1:0] idx;
  logic           grant_found;
  logic           handshake;
  logic [W-1:0]   sel_data;
  logic [CW-1:0]  sel_cnt;

  // Round-robin search: first requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    grant       = '0;
    idx         = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IDW'(k);
      if (!grant_found && req_val[idx]) begin
        grant       = idx;
        grant_found = 1'b1;
      end
    end
  end

  assign sel_data  = req_data[int'(grant)*W +: W];
  assign sel_cnt   = req_cnt[int'(grant)*CW +: CW];
  assign handshake = (state == IDLE) && grant_found && !reset;
  assign req_rdy   = handshake ? (NREQ'(1) << grant) : '0;

  // Next-state logic: accept in IDLE, count down in BUSY, wait for consumer in DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = (sel_cnt == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (remaining == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops any in-flight job
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Job registers: capture on acceptance, increment and count down while BUSY
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      id        <= '0;
      acc       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            acc       <= sel_data;
            remaining <= sel_cnt;
            id        <= grant;
            ptr       <= grant + IDW'(1);
          end
        end
        BUSY: begin
          acc       <= acc + W'(1);
          remaining <= remaining - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign resp_val  = (state == DONE) && !reset;
  assign busy      = ((state == BUSY) || (state == DONE)) && !reset;
  assign resp_data = reset ? '0 : acc;
  assign resp_id   = reset ? '0 : id;

endmodule

// File: tb/tb_regincr_rr_sched.sv
// tb_regincr_rr_sched: table-driven single-request vectors plus hand-written
// round-robin, backpressure and mid-operation reset sequences. A negedge
// monitor keeps a reference arbiter and a scoreboard of expected responses.
module tb_regincr_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int IDW  = $clog2(NREQ);

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_val;
  logic [NREQ-1:0]    req_rdy;
  logic [NREQ*W-1:0]  req_data;
  logic [NREQ*CW-1:0] req_cnt;
  logic               resp_val;
  logic               resp_rdy;
  logic [W-1:0]       resp_data;
  logic [IDW-1:0]     resp_id;
  logic               busy;

  regincr_rr_sched #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_data  (req_data),
    .req_cnt   (req_cnt),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data),
    .resp_id   (resp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int cnt;
    int acc_cyc;
  } exp_t;

  typedef struct {
    int id;
    int data;
    int cnt;
    int exp_data;
    int exp_id;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   log_data[$];
  int   log_id[$];
  int   n_accept = 0;
  int   n_resp = 0;
  int   cyc = 0;
  int   m_ptr = 0;
  bit   m_idle = 1'b1;
  bit   first_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference monitor: expected grant from its own pointer, scoreboard of results
  always @(negedge clk) begin
    int   g;
    int   exp_rdy;
    exp_t e;
    cyc++;
    if (reset) begin
      check("reset_req_rdy", int'(req_rdy), 0);
      check("reset_resp_val", int'(resp_val), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_resp_data", int'(resp_data), 0);
      check("reset_resp_id", int'(resp_id), 0);
      sb.delete();
      m_idle     = 1'b1;
      m_ptr      = 0;
      first_seen = 1'b0;
    end else begin
      check("busy", int'(busy), m_idle ? 0 : 1);
      g       = -1;
      exp_rdy = 0;
      if (m_idle) begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (g < 0 && req_val[i]) g = i;
        end
      end
      if (g >= 0) exp_rdy = 1 << g;
      check("req_rdy", int'(req_rdy), exp_rdy);
      if (g >= 0) begin
        e.id      = g;
        e.cnt     = int'(req_cnt[g*CW +: CW]);
        e.data    = (int'(req_data[g*W +: W]) + e.cnt) % 256;
        e.acc_cyc = cyc;
        sb.push_back(e);
        m_ptr  = (g + 1) % NREQ;
        m_idle = 1'b0;
        n_accept++;
      end
      if (sb.size() == 0) begin
        check("resp_val_unexpected", int'(resp_val), 0);
      end else if (first_seen) begin
        check("resp_val_hold", int'(resp_val), 1);
      end
      if (sb.size() != 0 && resp_val) begin
        if (!first_seen) begin
          check("latency", cyc - sb[0].acc_cyc, sb[0].cnt + 1);
          first_seen = 1'b1;
        end
        check("resp_data", int'(resp_data), sb[0].data);
        check("resp_id", int'(resp_id), sb[0].id);
        if (resp_rdy) begin
          log_data.push_back(int'(resp_data));
          log_id.push_back(int'(resp_id));
          void'(sb.pop_front());
          first_seen = 1'b0;
          m_idle     = 1'b1;
          n_resp++;
        end
      end
    end
  end

  task automatic doReset();
    req_val = '0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input int data, input int cnt);
    int start;
    bit ok;
    start = n_accept;
    ok    = 1'b0;
    req_val = '0;
    req_val[idx] = 1'b1;
    req_data[idx*W +: W] = W'(data);
    req_cnt[idx*CW +: CW] = CW'(cnt);
    for (int t = 0; t < 20 && !ok; t++) begin
      @(posedge clk);
      #1;
      if (n_accept != start) ok = 1'b1;
    end
    req_val = '0;
    check("accept_timeout", int'(ok), 1);
  endtask

  task automatic waitResp(input int target, input int bound, input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < bound && !ok; t++) begin
      if (n_resp >= target) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check(name, int'(ok), 1);
  endtask

  task automatic checkOutput(input string name, input int pos, input int exp_data, input int exp_id);
    if (pos < 0 || pos >= log_data.size()) begin
      check({name, "_missing"}, pos, log_data.size() - 1);
    end else begin
      check({name, "_data"}, log_data[pos], exp_data);
      check({name, "_id"}, log_id[pos], exp_id);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    vec_t vecs[5];
    int   base;
    int   rr_id[5];
    int   rr_data[5];
    bit   ok;

    vecs[0] = '{id: 0, data: 'h10, cnt: 1,  exp_data: 'h11, exp_id: 0};
    vecs[1] = '{id: 2, data: 'hFE, cnt: 3,  exp_data: 'h01, exp_id: 2};
    vecs[2] = '{id: 1, data: 'h5A, cnt: 0,  exp_data: 'h5A, exp_id: 1};
    vecs[3] = '{id: 3, data: 'hFF, cnt: 15, exp_data: 'h0E, exp_id: 3};
    vecs[4] = '{id: 0, data: 'h7F, cnt: 1,  exp_data: 'h80, exp_id: 0};
    rr_id   = '{0, 1, 2, 3, 0};
    rr_data = '{'h01, 'h11, 'h21, 'h31, 'h01};

    reset    = 1'b1;
    req_val  = '0;
    req_data = '0;
    req_cnt  = '0;
    resp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] single-request vectors");
    for (int v = 0; v < 5; v++) begin
      base = n_resp;
      applyStimulus(vecs[v].id, vecs[v].data, vecs[v].cnt);
      waitResp(base + 1, 40, "vec_resp_timeout");
      checkOutput("vec", base, vecs[v].exp_data, vecs[v].exp_id);
    end

    $display("[TB] round-robin with all requesters active");
    doReset();
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*W +: W]   = W'(i * 'h10);
      req_cnt[i*CW +: CW]  = CW'(1);
    end
    base    = n_resp;
    req_val = '1;
    waitResp(base + 5, 100, "rr_resp_timeout");
    req_val = '0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("rr", base + k, rr_data[k], rr_id[k]);
    end
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (sb.size() == 0 && m_idle) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("rr_drain_timeout", int'(ok), 1);

    $display("[TB] backpressure in DONE");
    doReset();
    resp_rdy = 1'b0;
    base = n_resp;
    applyStimulus(0, 'h33, 2);
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      if (first_seen) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("bp_resp_val_timeout", int'(ok), 1);
    req_val = 4'b1110;
    repeat (5) @(posedge clk);
    #1;
    check("bp_no_early_resp", n_resp, base);
    req_val  = '0;
    resp_rdy = 1'b1;
    waitResp(base + 1, 5, "bp_resp_timeout");
    checkOutput("bp", base, 'h35, 0);
    @(negedge clk);
    check("bp_idle_after", int'(busy), 0);
    @(posedge clk);
    #1;

    $display("[TB] reset during BUSY");
    doReset();
    applyStimulus(0, 'h00, 10);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_resp_val", int'(resp_val), 0);
    check("mid_reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = n_resp;
    req_data[0*W +: W]   = W'('h44);
    req_cnt[0*CW +: CW]  = CW'(0);
    req_data[3*W +: W]   = W'('h77);
    req_cnt[3*CW +: CW]  = CW'(0);
    req_val = 4'b1001;
    waitResp(base + 2, 20, "post_reset_resp_timeout");
    req_val = '0;
    checkOutput("post_reset_first", base, 'h44, 0);
    checkOutput("post_reset_second", base + 1, 'h77, 3);
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_resp_count", n_resp, base + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
